bram_lsu_port: RTL

- Initiator-side bridge between a CPU load/store request stream and a single-port byte-write read-first BRAM. The BRAM has 4 x 8-bit columns and a fixed read latency.
- Converts byte-addressed loads/stores of byte, half or word size into BRAM word address, column write enables and lane-shifted write data.
- Tracks the BRAM's fixed read latency with a tag pipeline. Aligns and extends returned load data.
- Returns in-order responses over a valid/ready channel. Backpressure is credit-based because the BRAM cannot stall.

---
 rtl/bram_lsu_pkg.sv | 65 ++++++
 rtl/bram_lsu_rsp_fifo.sv | 70 +++++++
 rtl/bram_lsu_port.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bram_lsu_pkg.sv
// Shared types and helpers for the BRAM load/store port.
// Holds the request tag, the response entry, byte-enable generation and load alignment.
package bram_lsu_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   typedef struct packed {
      logic       is_load;
      logic [1:0] size;
      logic       is_unsigned;
      logic [1:0] off;
      logic       err;
   } lsu_tag_t;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } rsp_t;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = off[0];
         SZ_W:    bad = (off != 2'd0);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SZ_B:    be = 4'b0001 << off;
         SZ_H:    be = 4'b0011 << off;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Shift the addressed lane down to bit 0, then truncate and extend to the access size.
   function automatic logic [DATA_W-1:0] load_align(input logic [DATA_W-1:0] dout,
                                                    input logic [1:0]        size,
                                                    input logic [1:0]        off,
                                                    input logic              is_unsigned);
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] res;
      sh = dout >> {off, 3'b000};
      case (size)
         SZ_B:    res = {{24{sh[7] & ~is_unsigned}}, sh[7:0]};
         SZ_H:    res = {{16{sh[15] & ~is_unsigned}}, sh[15:0]};
         SZ_W:    res = sh;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/bram_lsu_rsp_fifo.sv
// Response FIFO: registered storage with the head visible the cycle after a push.
// Push is refused only when full and nothing is leaving, so push+pop is legal at any occupancy.
module bram_lsu_rsp_fifo
   import bram_lsu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  rsp_t             push_data,
   input  logic             pop,
   output rsp_t             head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rsp_t             mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   // Qualify push/pop against occupancy.
   always_comb begin
      do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
      do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
   end

   // Entry storage; contents need no reset because occupancy gates the head.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign empty = (count_r == {CNT_W{1'b0}});
   assign count = count_r;

endmodule

// File: rtl/bram_lsu_port.sv
// CPU load/store port onto a byte-write, read-first BRAM with fixed read latency.
// Requests are credit-gated so the in-order response FIFO can never overflow.
module bram_lsu_port
   import bram_lsu_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int RD_LATENCY = 2,
   parameter int RSP_DEPTH  = 4
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic [3:0]        mem_we,
   output logic              mem_en,
   output logic              mem_regce,
   output logic              mem_rst,
   input  logic [31:0]       mem_dout
);

   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int OUT_W = $clog2(RSP_DEPTH + RD_LATENCY + 1);
   localparam int LAST  = RD_LATENCY - 1;

   logic [1:0]       off_s;
   logic             err_s;
   logic             issue_s;
   lsu_tag_t         new_tag_s;
   logic             valid_r [RD_LATENCY];
   lsu_tag_t         tag_r   [RD_LATENCY];
   rsp_t             retire_s;
   rsp_t             head_s;
   logic             empty_s;
   logic [CNT_W-1:0] fifo_count_s;
   logic [OUT_W-1:0] outstanding_s;

   // Credits: every queued response plus every request still in the read pipeline.
   always_comb begin
      outstanding_s = OUT_W'(fifo_count_s);
      for (int i = 0; i < RD_LATENCY; i++) begin
         outstanding_s = outstanding_s + OUT_W'(valid_r[i]);
      end
   end

   assign req_ready = !rsta && (outstanding_s < OUT_W'(RSP_DEPTH));

   // Decode the request straight onto the BRAM port.
   always_comb begin
      off_s    = req_addr[1:0];
      err_s    = misaligned(req_size, off_s);
      issue_s  = req_valid && req_ready;
      mem_addr = req_addr[ADDR_W+1:2];
      mem_en   = issue_s && !err_s;
      if (mem_en && req_we) begin
         mem_we = be_gen(req_size, off_s);
      end else begin
         mem_we = 4'b0000;
      end
      case (req_size)
         SZ_B:    mem_din = {4{req_wdata[7:0]}};
         SZ_H:    mem_din = {2{req_wdata[15:0]}};
         default: mem_din = req_wdata;
      endcase
      new_tag_s = '{is_load: !req_we, size: req_size, is_unsigned: req_unsigned,
                    off: off_s, err: err_s};
   end

   // Tag pipeline mirrors the BRAM read latency; it shifts every cycle.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            valid_r[i] <= 1'b0;
            tag_r[i]   <= {$bits(lsu_tag_t){1'b0}};
         end
      end else begin
         valid_r[0] <= issue_s;
         tag_r[0]   <= new_tag_s;
         for (int i = 1; i < RD_LATENCY; i++) begin
            valid_r[i] <= valid_r[i-1];
            tag_r[i]   <= tag_r[i-1];
         end
      end
   end

   // Build the response for the entry leaving the pipeline; only clean loads carry data.
   always_comb begin
      retire_s.err = tag_r[LAST].err;
      if (tag_r[LAST].is_load && !tag_r[LAST].err) begin
         retire_s.rdata = load_align(mem_dout, tag_r[LAST].size, tag_r[LAST].off,
                                     tag_r[LAST].is_unsigned);
      end else begin
         retire_s.rdata = 32'h0000_0000;
      end
   end

   bram_lsu_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .CNT_W (CNT_W)
   ) u_rsp_fifo (
      .clk       (clka),
      .rst       (rsta),
      .push      (valid_r[LAST]),
      .push_data (retire_s),
      .pop       (rsp_ready),
      .head      (head_s),
      .empty     (empty_s),
      .count     (fifo_count_s)
   );

   assign rsp_valid = !empty_s;
   assign rsp_rdata = empty_s ? 32'h0000_0000 : head_s.rdata;
   assign rsp_err   = !empty_s && head_s.err;
   assign mem_regce = 1'b1;
   assign mem_rst   = 1'b0;

endmodule
